opl3_reg_sched: RTL



---
 rtl/opl3_reg_sched_pkg.sv | 30 +++
 rtl/opl3_reg_sched_if.sv | 24 ++
 rtl/opl3_reg_sched_timer.sv | 39 +++
 rtl/opl3_reg_sched.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/opl3_reg_sched_pkg.sv
// Shared types and constants for the OPL3 register front end.
// Holds the sequencing state enum, the timer/control register indices and
// small address/byte-lane helpers used by the scheduler top.
package opl3_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DECODE,
    WAITG,
    WRITE
  } state_t;

  // Bank 0 indices
  localparam logic [7:0] REG_T1   = 8'h02;
  localparam logic [7:0] REG_T2   = 8'h03;
  localparam logic [7:0] REG_TCTL = 8'h04;
  // Bank 1 indices
  localparam logic [7:0] REG_CONN = 8'h04;
  localparam logic [7:0] REG_NEW  = 8'h05;

  // Two byte registers share one 16-bit RAM word; bank 1 sits 0x80 words up.
  function automatic logic [11:0] reg_addr(input logic [11:0] base, input logic [8:0] idx);
    return base + {4'b0000, idx[8], idx[7:1]};
  endfunction

  function automatic logic [1:0] lane_be(input logic lsb);
    return lsb ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/opl3_reg_sched_if.sv
// Host-queue and structure-RAM signal bundle for the register scheduler.
// master: scheduler side (pops queue, drives RAM port B write signals).
// slave:  environment side (queue read port, sequencer busy, RAM).
interface opl3_reg_sched_if;
  logic [9:0]  q_data;
  logic        q_empty;
  logic        q_rdreq;
  logic        seq_busy;
  logic [11:0] struct_base;
  logic        ram_we;
  logic [11:0] ram_addr;
  logic [1:0]  ram_be;
  logic [15:0] ram_wdata;

  modport master (
    input  q_data, q_empty, seq_busy, struct_base,
    output q_rdreq, ram_we, ram_addr, ram_be, ram_wdata
  );

  modport slave (
    output q_data, q_empty, seq_busy, struct_base,
    input  q_rdreq, ram_we, ram_addr, ram_be, ram_wdata
  );
endinterface

// File: rtl/opl3_reg_sched_timer.sv
// One OPL3 8-bit up-counting timer with preset reload and maskable flag.
// Ports: clk/reset; preset, start, mask, tick, load (start edge), clr in; flag out.
// Flag updates on the clock edge of the wrapping tick; a clear in that same cycle wins.
module opl3_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] preset,
  input  logic       start,
  input  logic       mask,
  input  logic       tick,
  input  logic       load,
  input  logic       clr,
  output logic       flag
);

  logic [7:0] cnt;
  logic       wrap;

  // A start edge reloads the counter and swallows any coincident tick.
  assign wrap = start && tick && !load && (cnt == 8'hFF);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= 8'h00;
      flag <= 1'b0;
    end else begin
      if (load)
        cnt <= preset;
      else if (start && tick)
        cnt <= (cnt == 8'hFF) ? preset : cnt + 8'h01;

      if (clr)
        flag <= 1'b0;
      else if (wrap && !mask)
        flag <= 1'b1;
    end
  end

endmodule

// File: rtl/opl3_reg_sched.sv
// OPL3 register front end: drains the host write queue, latches the register
// index per bank, schedules byte-lane writes into structure RAM around the
// sequencer, and implements timer/status (0x02-0x04) plus NEW/4-op (0x105/0x104).
// Ports: clk, reset; bus (queue + RAM port B); opl3_new, conn4op, status, irq.
module opl3_reg_sched
  import opl3_pkg::*;
#(
  parameter int OPLCLK = 50000000,
  parameter int TICK80 = OPLCLK / 12500
) (
  input  logic              clk,
  input  logic              reset,
  opl3_reg_sched_if.master  bus,
  output logic              opl3_new,
  output logic [5:0]        conn4op,
  output logic [7:0]        status,
  output logic              irq
);

  localparam int PW = (TICK80 > 1) ? $clog2(TICK80) : 1;

  state_t      state, state_nxt;
  logic        pop, grant;
  logic [9:0]  ent;
  logic [8:0]  idx;
  logic [7:0]  d;
  logic [7:0]  t1_preset, t2_preset;
  logic        mask1, mask2, st1, st2;
  logic        wr, tctl_clr, tctl_set, load1, load2;
  logic [PW-1:0] pre;
  logic [1:0]  div;
  logic        tick80, tick320;
  logic        t1_flag, t2_flag;

  assign d = ent[7:0];

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    grant     = 1'b0;
    case (state)
      IDLE: if (!bus.q_empty) begin
        pop       = 1'b1;
        state_nxt = DECODE;
      end
      DECODE: state_nxt = ent[8] ? WAITG : IDLE;
      // RAM grant is sampled here only; busy during WRITE is ignored.
      WAITG: if (!bus.seq_busy) begin
        grant     = 1'b1;
        state_nxt = WRITE;
      end
      WRITE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Register side effects are decoded during the WRITE cycle.
  always_comb begin
    wr       = (state == WRITE);
    tctl_clr = wr && (idx == {1'b0, REG_TCTL}) && d[7];
    tctl_set = wr && (idx == {1'b0, REG_TCTL}) && !d[7];
    load1    = tctl_set && d[0] && !st1;
    load2    = tctl_set && d[1] && !st2;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      ent           <= '0;
      idx           <= '0;
      bus.q_rdreq   <= 1'b0;
      bus.ram_we    <= 1'b0;
      bus.ram_addr  <= '0;
      bus.ram_be    <= '0;
      bus.ram_wdata <= '0;
      t1_preset     <= '0;
      t2_preset     <= '0;
      mask1         <= 1'b0;
      mask2         <= 1'b0;
      st1           <= 1'b0;
      st2           <= 1'b0;
      opl3_new      <= 1'b0;
      conn4op       <= '0;
      status        <= '0;
      irq           <= 1'b0;
    end else begin
      state       <= state_nxt;
      // Entry is captured now; the pop strobe follows in DECODE so the
      // show-ahead head advances before the next IDLE looks at it.
      bus.q_rdreq <= pop;
      if (pop)
        ent <= bus.q_data;

      // Bank 1 is only reachable with NEW=1, except 0x105 itself.
      if (state == DECODE && !ent[8])
        idx <= {ent[9] & (opl3_new | (d == REG_NEW)), d};

      bus.ram_we <= grant;
      if (grant) begin
        bus.ram_addr  <= reg_addr(bus.struct_base, idx);
        bus.ram_be    <= lane_be(idx[0]);
        bus.ram_wdata <= {d, d};
      end

      if (wr) begin
        case (idx)
          {1'b0, REG_T1}: t1_preset <= d;
          {1'b0, REG_T2}: t2_preset <= d;
          {1'b0, REG_TCTL}: if (!d[7]) begin
            mask1 <= d[6];
            mask2 <= d[5];
            st2   <= d[1];
            st1   <= d[0];
          end
          {1'b1, REG_CONN}: conn4op  <= d[5:0];
          {1'b1, REG_NEW}:  opl3_new <= d[0];
          default: ;
        endcase
      end

      status <= {t1_flag | t2_flag, t1_flag, t2_flag, 5'b00000};
      irq    <= t1_flag | t2_flag;
    end
  end

  // Free-running 80 us prescaler with a /4 stage for the 320 us timer.
  assign tick80  = (pre == PW'(TICK80 - 1));
  assign tick320 = tick80 && (div == 2'd3);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre <= '0;
      div <= '0;
    end else begin
      pre <= tick80 ? '0 : pre + 1'b1;
      if (tick80)
        div <= div + 2'd1;
    end
  end

  opl3_timer u_t1 (
    .clk(clk), .reset(reset), .preset(t1_preset), .start(st1), .mask(mask1),
    .tick(tick80), .load(load1), .clr(tctl_clr), .flag(t1_flag)
  );

  opl3_timer u_t2 (
    .clk(clk), .reset(reset), .preset(t2_preset), .start(st2), .mask(mask2),
    .tick(tick320), .load(load2), .clr(tctl_clr), .flag(t2_flag)
  );

endmodule
